// File: rtl/rgb_led_pwm_ctrl.sv
// rgb_led_pwm_ctrl
//
// Drives NUM_LED RGB LEDs with a shared PWM engine. Eight asynchronous push
// buttons are synchronised and debounced. Buttons 0..6 select a colour from a
// fixed palette, and button 7 toggles chase mode. In chase mode only one LED
// at a time carries the colour, and the lit LED steps along the strip.
//
// Optional feature macro: RGB_LED_FADE_EN
//   defined   : at each PWM period boundary every current duty steps by one
//               toward its target, giving a smooth fade.
//   undefined : at each PWM period boundary every current duty loads its
//               target directly.
//
// Ports
//   clk           system clock, rising-edge active
//   rst           synchronous active-high reset
//   btn[7:0]      asynchronous active-high push buttons
//   led_signal_R  red PWM drive, one bit per LED
//   led_signal_G  green PWM drive, one bit per LED
//   led_signal_B  blue PWM drive, one bit per LED

module rgb_led_pwm_ctrl #(
    parameter int NUM_LED      = 4,
    parameter int PWM_W        = 8,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CHASE_CYC    = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         btn,
    output logic [NUM_LED-1:0] led_signal_R,
    output logic [NUM_LED-1:0] led_signal_G,
    output logic [NUM_LED-1:0] led_signal_B
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int CH_W  = (CHASE_CYC > 1) ? $clog2(CHASE_CYC) : 1;
    localparam int IDX_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    localparam logic [PWM_W-1:0] FS       = '1;
    localparam logic [PWM_W-1:0] HALF     = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic [PWM_W-1:0] CNT_LAST = FS - 1'b1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHASE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LED - 1);

    logic [7:0]         sync_q1, sync_q2;
    logic [DB_W-1:0]    db_cnt [8];
    logic [7:0]         db_level;
    logic [7:0]         btn_rise;

    logic               color_hit;
    logic [PWM_W-1:0]   new_r, new_g, new_b;
    logic [PWM_W-1:0]   tgt_r, tgt_g, tgt_b;
    logic [PWM_W-1:0]   duty_r, duty_g, duty_b;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               pwm_wrap;

    logic               chase_on;
    logic [IDX_W-1:0]   chase_idx;
    logic [CH_W-1:0]    chase_tmr;
    logic [NUM_LED-1:0] led_mask;

    // Two-flop synchroniser to bring the asynchronous buttons into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYC consecutive samples that
    // differ from the accepted level. Any sample equal to the accepted level
    // restarts the count. btn_rise is a one-cycle pulse on each accepted 0->1
    // transition, so a held button produces exactly one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
            db_level <= '0;
            btn_rise <= '0;
        end else begin
            btn_rise <= '0;
            for (int i = 0; i < 8; i++) begin
                if (sync_q2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= sync_q2[i];
                    btn_rise[i] <= sync_q2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Palette lookup. The if-chain gives priority to the lowest button index.
    always_comb begin
        color_hit = 1'b1;
        new_r     = '0;
        new_g     = '0;
        new_b     = '0;
        if (btn_rise[0]) begin
            new_r = FS;
        end else if (btn_rise[1]) begin
            new_g = FS;
        end else if (btn_rise[2]) begin
            new_b = FS;
        end else if (btn_rise[3]) begin
            new_r = FS;
            new_g = FS;
        end else if (btn_rise[4]) begin
            new_g = FS;
            new_b = FS;
        end else if (btn_rise[5]) begin
            new_r = FS;
            new_b = FS;
        end else if (btn_rise[6]) begin
            new_r = HALF;
            new_g = HALF;
            new_b = HALF;
        end else begin
            color_hit = 1'b0;
        end
    end

    // Colour targets and chase state. A btn7 edge toggles chase mode and restarts
    // the chase at LED 0. The toggle is independent of any colour edge in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r     <= '0;
            tgt_g     <= '0;
            tgt_b     <= '0;
            chase_on  <= 1'b0;
            chase_idx <= '0;
            chase_tmr <= '0;
        end else begin
            if (color_hit) begin
                tgt_r <= new_r;
                tgt_g <= new_g;
                tgt_b <= new_b;
            end
            if (btn_rise[7]) begin
                chase_on  <= ~chase_on;
                chase_idx <= '0;
                chase_tmr <= '0;
            end else if (chase_on) begin
                if (chase_tmr == CH_LAST) begin
                    chase_tmr <= '0;
                    chase_idx <= (chase_idx == IDX_LAST) ? '0 : chase_idx + 1'b1;
                end else begin
                    chase_tmr <= chase_tmr + 1'b1;
                end
            end
        end
    end

    assign pwm_wrap = (pwm_cnt == CNT_LAST);

`ifdef RGB_LED_FADE_EN
    function automatic logic [PWM_W-1:0] fade_step(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction
`endif

    // PWM counter runs 0..FS-1. Duties change only when the counter wraps. This
    // keeps every period glitch-free, and the new duty is in force from counter
    // value 0 onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
        end else begin
            pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 1'b1;
            if (pwm_wrap) begin
`ifdef RGB_LED_FADE_EN
                duty_r <= fade_step(duty_r, tgt_r);
                duty_g <= fade_step(duty_g, tgt_g);
                duty_b <= fade_step(duty_b, tgt_b);
`else
                duty_r <= tgt_r;
                duty_g <= tgt_g;
                duty_b <= tgt_b;
`endif
            end
        end
    end

    // In chase mode only the LED at chase_idx is enabled. Otherwise all LEDs are enabled.
    always_comb begin
        led_mask = '1;
        if (chase_on) begin
            for (int i = 0; i < NUM_LED; i++) begin
                led_mask[i] = (chase_idx == IDX_W'(i));
            end
        end
    end

    // Registered outputs. Reset forces them low on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_signal_R <= '0;
            led_signal_G <= '0;
            led_signal_B <= '0;
        end else begin
            led_signal_R <= (pwm_cnt < duty_r) ? led_mask : '0;
            led_signal_G <= (pwm_cnt < duty_g) ? led_mask : '0;
            led_signal_B <= (pwm_cnt < duty_b) ? led_mask : '0;
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb_rgb_led_pwm_ctrl
//
// Bench for rgb_led_pwm_ctrl with NUM_LED=4, PWM_W=4 (FS=15), DEBOUNCE_CYC=4
// and CHASE_CYC=30. Colour vectors come from a table. Their expected
// per-period on-counts go into a scoreboard queue and are popped when the
// output window is measured. Chase, hold, reset and fade corner cases are
// written out by hand.

module tb_rgb_led_pwm_ctrl;

    localparam int NUM_LED = 4;
    localparam int PWM_W   = 4;
    localparam int FS      = 15;
    localparam int DEB     = 4;
    localparam int CHASE   = 30;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         btn;
    logic [NUM_LED-1:0] led_r, led_g, led_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] btn;
        int         hold;
        int         r_on;
        int         g_on;
        int         b_on;
    } vec_t;

    typedef struct {
        int r_on;
        int g_on;
        int b_on;
    } exp_t;

    vec_t vecs[11];
    exp_t exp_q[$];

    rgb_led_pwm_ctrl #(
        .NUM_LED      (NUM_LED),
        .PWM_W        (PWM_W),
        .DEBOUNCE_CYC (DEB),
        .CHASE_CYC    (CHASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .led_signal_R (led_r),
        .led_signal_G (led_g),
        .led_signal_B (led_b)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive a button pattern for a number of cycles, then leave rest_val on the
    // buttons and give debounce plus one PWM period time to settle.
    task automatic applyStimulus(input logic [7:0] b, input int hold, input logic [7:0] rest_val);
        btn = b;
        repeat (hold) tick();
        btn = rest_val;
        repeat (30) tick();
    endtask

    // Measure one full PWM period and compare per-colour all-on counts with the
    // next scoreboard entry. Any partially lit pattern counts as mixed.
    task automatic checkOutput(input string tag);
        exp_t e;
        int r_on, g_on, b_on, bad;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: scoreboard entries got 0, expected 1", tag);
            return;
        end
        e    = exp_q.pop_front();
        r_on = 0;
        g_on = 0;
        b_on = 0;
        bad  = 0;
        for (int c = 0; c < FS; c++) begin
            r_on += (led_r == 4'hF) ? 1 : 0;
            g_on += (led_g == 4'hF) ? 1 : 0;
            b_on += (led_b == 4'hF) ? 1 : 0;
            bad  += ((led_r != 4'h0 && led_r != 4'hF) ||
                     (led_g != 4'h0 && led_g != 4'hF) ||
                     (led_b != 4'h0 && led_b != 4'hF)) ? 1 : 0;
            tick();
        end
        check({tag, "_R_on"}, r_on, e.r_on);
        check({tag, "_G_on"}, g_on, e.g_on);
        check({tag, "_B_on"}, b_on, e.b_on);
        check({tag, "_mixed"}, bad, 0);
    endtask

    task automatic waitFor(input logic [3:0] val, input int limit, output bit found);
        int n;
        n = 0;
        while (led_r != val && n < limit) begin
            tick();
            n++;
        end
        found = (led_r == val);
    endtask

    // Count consecutive samples equal to the current red value, up to a limit.
    task automatic runLength(input int limit, output int len);
        logic [3:0] v;
        v   = led_r;
        len = 0;
        while (led_r == v && len < limit) begin
            len++;
            tick();
        end
    endtask

    task automatic resetTest();
        rst = 1'b1;
        btn = 8'h01;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("reset_hold_%0d", i), {20'd0, led_r, led_g, led_b}, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < FS; i++) begin
            tick();
            check($sformatf("post_release_%0d", i), {20'd0, led_r, led_g, led_b}, 0);
        end
        repeat (20) tick();
        btn = 8'h00;
        repeat (20) tick();
    endtask

`ifdef RGB_LED_FADE_EN
    task automatic fadeTest();
        int  len;
        bit  found;
        btn = 8'h01;
        repeat (10) tick();
        btn = 8'h00;
        for (int d = 1; d <= 7; d++) begin
            found = 1'b0;
            for (int n = 0; n < 40 && led_r == 4'h0; n++) tick();
            runLength(40, len);
            check($sformatf("fade_a_duty%0d", d), len, d);
        end
        rst = 1'b1;
        tick();
        check("fade_rst_out", {20'd0, led_r, led_g, led_b}, 0);
        tick();
        rst = 1'b0;
        exp_q.push_back('{0, 0, 0});
        checkOutput("fade_after_rst");
        btn = 8'h01;
        repeat (10) tick();
        btn = 8'h00;
        for (int d = 1; d <= 14; d++) begin
            for (int n = 0; n < 40 && led_r == 4'h0; n++) tick();
            runLength(40, len);
            check($sformatf("fade_b_duty%0d", d), len, d);
        end
        waitFor(4'hF, 40, found);
        check("fade_full_reached", int'(found), 1);
        runLength(60, len);
        check("fade_full_on", len, 60);
    endtask
`else
    task automatic mainTests();
        int         len;
        bit         found;
        logic [3:0] seg_exp [4];

        vecs[0]  = '{8'h01, 10, 15, 0, 0};
        vecs[1]  = '{8'h40, 10, 8, 8, 8};
        vecs[2]  = '{8'h01, 2, 8, 8, 8};
        vecs[3]  = '{8'h01, 3, 8, 8, 8};
        vecs[4]  = '{8'h06, 10, 0, 15, 0};
        vecs[5]  = '{8'h04, 10, 0, 0, 15};
        vecs[6]  = '{8'h08, 10, 15, 15, 0};
        vecs[7]  = '{8'h10, 10, 0, 15, 15};
        vecs[8]  = '{8'h20, 10, 15, 0, 15};
        vecs[9]  = '{8'h7E, 10, 0, 15, 0};
        vecs[10] = '{8'h01, 4, 15, 0, 0};

        for (int i = 0; i < 11; i++) begin
            exp_q.push_back('{vecs[i].r_on, vecs[i].g_on, vecs[i].b_on});
            applyStimulus(vecs[i].btn, vecs[i].hold, 8'h00);
            checkOutput($sformatf("vec%0d", i));
        end

        // Held button must not retrigger after another colour is chosen.
        exp_q.push_back('{0, 0, 15});
        applyStimulus(8'h04, 10, 8'h04);
        checkOutput("hold_blue");
        exp_q.push_back('{15, 0, 0});
        applyStimulus(8'h05, 10, 8'h04);
        checkOutput("hold_no_retrig");
        btn = 8'h00;
        repeat (20) tick();

        // Chase: one-hot red walking 0->1->2->3->0, 30 cycles per step.
        btn = 8'h80;
        repeat (10) tick();
        btn = 8'h00;
        waitFor(4'b0010, 100, found);
        check("chase_reach_bit1", int'(found), 1);
        seg_exp[0] = 4'b0010;
        seg_exp[1] = 4'b0100;
        seg_exp[2] = 4'b1000;
        seg_exp[3] = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("chase_val%0d", k), int'(led_r), int'(seg_exp[k]));
            runLength(100, len);
            check($sformatf("chase_len%0d", k), len, CHASE);
        end
        check("chase_wrap_val", int'(led_r), int'(4'b0010));

        exp_q.push_back('{15, 0, 0});
        applyStimulus(8'h80, 10, 8'h00);
        checkOutput("chase_off");

        // Reset in the middle of a chase clears everything, including chase mode.
        btn = 8'h80;
        repeat (10) tick();
        btn = 8'h00;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_chase", {20'd0, led_r, led_g, led_b}, 0);
        repeat (3) tick();
        rst = 1'b0;
        exp_q.push_back('{0, 0, 0});
        checkOutput("post_rst_dark");
        exp_q.push_back('{15, 0, 0});
        applyStimulus(8'h01, 10, 8'h00);
        checkOutput("post_rst_red");
    endtask
`endif

    initial begin
        rst = 1'b1;
        btn = 8'h00;
        resetTest();
`ifdef RGB_LED_FADE_EN
        fadeTest();
`else
        mainTests();
`endif
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time got 600000, expected less");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rgb_led_pwm_ctrl.md
RGB_LED_PWM_CTRL -- requirements
Module: rgb_led_pwm_ctrl

Interface
REQ-001 Parameter NUM_LED, default 4: number of RGB LEDs driven.
REQ-002 Parameter PWM_W, default 8: duty/counter width; full scale FS = 2^PWM_W-1.
REQ-003 Parameter DEBOUNCE_CYC, default 1000: stable cycles required to accept a button level (1 ms at 1 MHz).
REQ-004 Parameter CHASE_CYC, default 250000: cycles per chase step.
REQ-005 clk  input  1  single system clock, rising-edge active.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn  input  8  asynchronous push buttons, active-high.
REQ-008 led_signal_R  output  NUM_LED  red PWM drive, one bit per LED.
REQ-009 led_signal_G  output  NUM_LED  green PWM drive, one bit per LED.
REQ-010 led_signal_B  output  NUM_LED  blue PWM drive, one bit per LED.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEBOUNCE_CYC consecutive equal samples.
REQ-012 Only a debounced 0->1 edge SHALL act; a held button SHALL NOT retrigger.
REQ-013 Color palette (R,G,B targets): btn0 (FS,0,0); btn1 (0,FS,0); btn2 (0,0,FS); btn3 (FS,FS,0); btn4 (0,FS,FS); btn5 (FS,0,FS); btn6 (H,H,H) with H = 2^(PWM_W-1).
REQ-014 Simultaneous edges on btn0..btn6 in one cycle: lowest index SHALL win.
REQ-015 btn7 edge SHALL toggle chase mode; a btn7 edge coinciding with a color edge SHALL apply both.
REQ-016 PWM counter SHALL count 0..FS-1 and wrap to 0 (period FS cycles); boundary = counter value 0.
REQ-017 Channel output SHALL be 1 when counter < current duty, else 0; duty FS gives constantly on, duty 0 constantly off.
REQ-018 Current duties SHALL update only at a boundary; a target change mid-period SHALL take effect at the next boundary (glitch-free).
REQ-019 Chase off: all NUM_LED bits of a color SHALL carry the same PWM waveform.
REQ-020 Chase on: only LED index idx SHALL be driven, others 0; idx SHALL advance 0..NUM_LED-1 and wrap to 0 every CHASE_CYC cycles.
REQ-021 Entering or leaving chase mode SHALL clear idx and the chase timer to 0.
REQ-022 Worst-case latency from btn edge to new duty: 2 + DEBOUNCE_CYC + 1 cycles plus up to FS cycles to the next boundary.

Reset
REQ-023 rst high SHALL clear synchronisers, debouncers (accepted level 0), targets, current duties, PWM counter, chase flag, idx and chase timer to 0.
REQ-024 All outputs SHALL be 0 in the cycle after rst is sampled high and while it remains high.
REQ-025 rst asserted mid-fade or mid-chase SHALL abort immediately; no prior state survives.

Configuration
REQ-026 Macro RGB_LED_FADE_EN defined: at each boundary each current duty SHALL step by exactly 1 toward its target, holding when equal.
REQ-027 Macro RGB_LED_FADE_EN undefined: at each boundary each current duty SHALL load its target directly; no fade logic SHALL be synthesised.

Verification (bench parameters: NUM_LED=4, PWM_W=4, FS=15, DEBOUNCE_CYC=4, CHASE_CYC=30; 1 MHz clk)
REQ-028 Reset: rst=1 for 20 cycles, btn=8'h01 -> all three outputs 4'b0000 throughout, and for one full period after release before debounce completes.
REQ-029 Color select, no fade: btn=8'h01 held 10 cycles -> from next boundary led_signal_R=4'b1111 for all 15 cycles, G=B=4'b0000; then btn=8'h40 -> each channel 4'b1111 for 8 of 15 cycles.
REQ-030 Debounce/priority: btn0 pulse of 2 cycles -> no output change; btn=8'h06 applied in one cycle -> green only (btn1 wins).
REQ-031 Chase: red active, btn7 pressed -> led_signal_R bit0 only for 30 cycles, then bit1, ..., bit3, then bit0; second btn7 press -> 4'b1111 again.
REQ-032 Fade (RGB_LED_FADE_EN): off -> btn0 -> R duty 1,2,...,15 over 15 consecutive periods; rst at duty 7 -> outputs 0 next cycle, duty 0 after release.
